// File: rtl/edge_event_arbiter.sv
// Edge-detecting event arbiter: per-channel sticky pending flags are served
// round-robin onto a single valid/ready event port, with sticky lost-event flags.
module edge_event_arbiter #(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned IDX_W = $clog2(N_CH),
    parameter int unsigned EDGE  = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_CH-1:0]  level,
    input  logic [N_CH-1:0]  enable,
    output logic             ev_valid,
    input  logic             ev_ready,
    output logic [IDX_W-1:0] ev_ch,
    output logic [N_CH-1:0]  pending,
    output logic [N_CH-1:0]  overflow,
    input  logic [N_CH-1:0]  clr_ovf
);

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    state_t           state;
    state_t           state_d;
    logic [N_CH-1:0]  dly;
    logic [N_CH-1:0]  edge_det;
    logic [N_CH-1:0]  offered;
    logic [N_CH-1:0]  acc;
    logic [IDX_W-1:0] last_grant;
    logic [IDX_W-1:0] last_grant_d;
    logic [IDX_W-1:0] ev_ch_d;
    logic [IDX_W-1:0] pick;
    logic             ev_valid_d;
    logic             found;
    int unsigned      search_idx;

    // Delay line; reset to 0 so a level already high at release reads as a rise
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dly <= '0;
        end else begin
            dly <= level;
        end
    end

    always_comb begin
        edge_det = '0;
        if (EDGE == 0) begin
            edge_det = level & ~dly;
        end else if (EDGE == 1) begin
            edge_det = ~level & dly;
        end else begin
            edge_det = level ^ dly;
        end
    end

    // Which channel is on the port, and whether it is being taken this cycle
    always_comb begin
        offered = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            offered[i] = ev_valid && (ev_ch == IDX_W'(i));
        end
        acc = offered & {N_CH{ev_ready}};
    end

    // A fresh edge re-arms pending even in its accept cycle; that is a new event
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending  <= '0;
            overflow <= '0;
        end else begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                if (edge_det[i] && enable[i]) begin
                    pending[i] <= 1'b1;
                end else if (acc[i]) begin
                    pending[i] <= 1'b0;
                end else if (!enable[i] && !offered[i]) begin
                    pending[i] <= 1'b0;
                end

                if (edge_det[i] && enable[i] && pending[i] && !acc[i]) begin
                    overflow[i] <= 1'b1;
                end else if (clr_ovf[i]) begin
                    overflow[i] <= 1'b0;
                end
            end
        end
    end

    // Round-robin search starting just after the last granted channel
    always_comb begin
        pick       = last_grant;
        found      = 1'b0;
        search_idx = 0;
        for (int unsigned k = 1; k <= N_CH; k++) begin
            search_idx = (32'(last_grant) + k) % N_CH;
            if (!found && pending[IDX_W'(search_idx)]) begin
                found = 1'b1;
                pick  = IDX_W'(search_idx);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            ev_valid   <= 1'b0;
            ev_ch      <= '0;
            last_grant <= IDX_W'(N_CH - 1);
        end else begin
            state      <= state_d;
            ev_valid   <= ev_valid_d;
            ev_ch      <= ev_ch_d;
            last_grant <= last_grant_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (|pending) state_d = OFFER;
            OFFER:   if (ev_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered port; an offer is held until taken
    always_comb begin
        ev_valid_d   = ev_valid;
        ev_ch_d      = ev_ch;
        last_grant_d = last_grant;
        case (state)
            IDLE: begin
                if (|pending) begin
                    ev_valid_d = 1'b1;
                    ev_ch_d    = pick;
                end
            end
            OFFER: begin
                if (ev_ready) begin
                    ev_valid_d   = 1'b0;
                    last_grant_d = ev_ch;
                end
            end
            default: ev_valid_d = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Scoreboard bench for edge_event_arbiter: a rising-edge instance for the main
// scenarios and a both-edges instance for enable gating.
module tb_edge_event_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;

    logic [3:0] level_a = '0;
    logic [3:0] enable_a = 4'hf;
    logic [3:0] clr_a = '0;
    logic       ready_a = 1'b0;
    logic       valid_a;
    logic [1:0] ch_a;
    logic [3:0] pending_a;
    logic [3:0] overflow_a;

    logic [3:0] level_b = '0;
    logic [3:0] enable_b = 4'b0111;
    logic [3:0] clr_b = '0;
    logic       ready_b = 1'b1;
    logic       valid_b;
    logic [1:0] ch_b;
    logic [3:0] pending_b;
    logic [3:0] overflow_b;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned exp_a[$];
    int unsigned exp_b[$];

    always #5 clk = ~clk;

    edge_event_arbiter #(.N_CH(4), .IDX_W(2), .EDGE(0)) dut (
        .clk      (clk),
        .reset    (reset),
        .level    (level_a),
        .enable   (enable_a),
        .ev_valid (valid_a),
        .ev_ready (ready_a),
        .ev_ch    (ch_a),
        .pending  (pending_a),
        .overflow (overflow_a),
        .clr_ovf  (clr_a)
    );

    edge_event_arbiter #(.N_CH(4), .IDX_W(2), .EDGE(2)) dut_b (
        .clk      (clk),
        .reset    (reset),
        .level    (level_b),
        .enable   (enable_b),
        .ev_valid (valid_b),
        .ev_ready (ready_b),
        .ev_ch    (ch_b),
        .pending  (pending_b),
        .overflow (overflow_b),
        .clr_ovf  (clr_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Every handshake pops the next expected channel
    always @(negedge clk) begin
        if (!reset && valid_a && ready_a) begin
            if (exp_a.size() == 0) check("a_extra_event_qdepth", 32'(exp_a.size()), 1);
            else check("a_ev_ch", 32'(ch_a), exp_a.pop_front());
        end
        if (!reset && valid_b && ready_b) begin
            if (exp_b.size() == 0) check("b_extra_event_qdepth", 32'(exp_b.size()), 1);
            else check("b_ev_ch", 32'(ch_b), exp_b.pop_front());
        end
    end

    initial begin
        int unsigned order[3];
        tick(2);
        check("rst_valid", 32'(valid_a), 0);
        check("rst_pending", 32'(pending_a), 0);
        check("rst_overflow", 32'(overflow_a), 0);
        check("rst_ch", 32'(ch_a), 0);
        reset = 1'b0;
        tick(2);

        // T3: simultaneous rises on 0,1,3 drain in order, two clocks apart
        ready_a = 1'b1;
        level_a = 4'b1011;
        order   = '{0, 1, 3};
        foreach (order[j]) exp_a.push_back(order[j]);
        tick(1);
        check("t3_pending", 32'(pending_a), 'hb);
        check("t3_valid_lat", 32'(valid_a), 0);
        foreach (order[j]) begin
            tick(1);
            check("t3_valid", 32'(valid_a), 1);
            check("t3_ch", 32'(ch_a), order[j]);
            tick(1);
            check("t3_gap", 32'(valid_a), 0);
        end
        check("t3_pending_done", 32'(pending_a), 0);

        // T2: single rise on ch2
        level_a = 4'b0100;
        exp_a.push_back(2);
        tick(1);
        check("t2_pending", 32'(pending_a), 'h4);
        check("t2_valid_lat", 32'(valid_a), 0);
        tick(1);
        check("t2_valid", 32'(valid_a), 1);
        check("t2_ch", 32'(ch_a), 2);
        tick(1);
        check("t2_valid_drop", 32'(valid_a), 0);
        check("t2_pending_clr", 32'(pending_a), 0);

        // T4: ch1 granted, then 3 and 0 follow in round-robin order
        level_a = '0;
        ready_a = 1'b0;
        tick(2);
        level_a = 4'b0010;
        exp_a.push_back(1);
        tick(1);
        check("t4_pending1", 32'(pending_a), 'h2);
        tick(1);
        check("t4_ch1", 32'(ch_a), 1);
        level_a = 4'b1011;
        tick(1);
        check("t4_pending", 32'(pending_a), 'hb);
        check("t4_hold_valid", 32'(valid_a), 1);
        check("t4_hold_ch", 32'(ch_a), 1);
        check("t4_no_ovf", 32'(overflow_a), 0);
        ready_a = 1'b1;
        exp_a.push_back(3);
        exp_a.push_back(0);
        tick(1);
        check("t4_pending_after", 32'(pending_a), 'h9);
        tick(1);
        check("t4_ch3", 32'(ch_a), 3);
        check("t4_valid3", 32'(valid_a), 1);
        tick(2);
        check("t4_ch0", 32'(ch_a), 0);
        check("t4_valid0", 32'(valid_a), 1);
        tick(1);
        check("t4_drain", 32'(pending_a), 0);

        // T5: second edge while held -> overflow; set beats clear
        level_a = '0;
        ready_a = 1'b0;
        tick(2);
        level_a = 4'b0010;
        exp_a.push_back(1);
        tick(2);
        check("t5_valid", 32'(valid_a), 1);
        level_a = '0;
        tick(1);
        level_a = 4'b0010;
        clr_a   = 4'b0010;
        tick(1);
        clr_a = '0;
        check("t5_ovf_set_wins", 32'(overflow_a), 'h2);
        check("t5_held_ch", 32'(ch_a), 1);
        tick(1);
        check("t5_ovf_sticky", 32'(overflow_a), 'h2);
        check("t5_held_valid", 32'(valid_a), 1);
        check("t5_pending", 32'(pending_a), 'h2);
        ready_a = 1'b1;
        tick(1);
        check("t5_accept_valid", 32'(valid_a), 0);
        check("t5_accept_pending", 32'(pending_a), 0);
        clr_a = 4'b0010;
        tick(1);
        clr_a = '0;
        check("t5_ovf_clr", 32'(overflow_a), 0);

        // T1: async reset mid-cycle while offering with an overflow set
        level_a = '0;
        ready_a = 1'b0;
        tick(2);
        level_a = 4'b1100;
        tick(1);
        check("t1_pending", 32'(pending_a), 'hc);
        tick(1);
        check("t1_ch2", 32'(ch_a), 2);
        level_a = '0;
        tick(1);
        level_a = 4'b1000;
        tick(1);
        check("t1_pre_ovf", 32'(overflow_a), 'h8);
        check("t1_pre_valid", 32'(valid_a), 1);
        #2;
        reset = 1'b1;
        #1;
        check("t1_rst_valid", 32'(valid_a), 0);
        check("t1_rst_pending", 32'(pending_a), 0);
        check("t1_rst_overflow", 32'(overflow_a), 0);
        check("t1_rst_ch", 32'(ch_a), 0);
        level_a = 4'b1010;
        ready_a = 1'b1;
        exp_a.push_back(1);
        exp_a.push_back(3);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick(1);
        check("t1_rel_pending", 32'(pending_a), 'ha);
        tick(1);
        check("t1_first_ch", 32'(ch_a), 1);
        check("t1_first_valid", 32'(valid_a), 1);
        tick(2);
        check("t1_second_ch", 32'(ch_a), 3);
        tick(1);
        check("t1_drain", 32'(pending_a), 0);

        // T6: both-edge instance, disabled channel ignores toggles
        for (int j = 0; j < 4; j++) begin
            level_b[3] = ~level_b[3];
            tick(1);
            check("t6_pend_dis", 32'(pending_b[3]), 0);
            check("t6_valid_dis", 32'(valid_b), 0);
        end
        tick(2);
        check("t6_valid_dis_late", 32'(valid_b), 0);
        enable_b[3] = 1'b1;
        tick(1);
        level_b[3] = 1'b1;
        exp_b.push_back(3);
        tick(1);
        check("t6_pending_rise", 32'(pending_b), 'h8);
        tick(1);
        check("t6_valid_rise", 32'(valid_b), 1);
        check("t6_ch_rise", 32'(ch_b), 3);
        tick(4);
        check("t6_single", 32'(valid_b), 0);
        level_b[3] = 1'b0;
        exp_b.push_back(3);
        tick(2);
        check("t6_valid_fall", 32'(valid_b), 1);
        check("t6_ch_fall", 32'(ch_b), 3);
        tick(3);

        check("a_queue_empty", 32'(exp_a.size()), 0);
        check("b_queue_empty", 32'(exp_b.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: time limit reached, errors=%0d of %0d checks", n_errors, n_checks);
        $fatal(1);
    end

endmodule
